// File: rtl/apb4_mst_pkg.sv
// Shared types and constants for the APB4 requester bridge.
package apb4_mst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_mst_tmo.sv
// PREADY stall counter: cleared before each ACCESS phase, flags expiry on the
// stalled ACCESS cycle that reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 never expires.
module apb4_mst_tmo #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  // Count holds the stalls already seen, so expiry fires when the current stall is the last allowed one.
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && ENABLED)  cnt <= cnt + CNT_W'(1);
  end

  assign expire = ENABLED && en && (cnt == LAST);

endmodule

// File: rtl/dffr.sv
// Register-library primitive: enabled D flip-flop with asynchronous active-low reset.
module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/apb4_mst_bridge.sv
// Single-outstanding APB4 initiator: valid/ready command in, SETUP/ACCESS on the
// bus, captured read data / error / timeout out on a valid/ready response channel.
module apb4_mst_bridge
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CMD_W  = ADDR_WIDTH + 1 + DATA_WIDTH + STRB_W;
  localparam int RSP_W  = DATA_WIDTH + 2;

  state_t            state_q, state_d;
  logic [1:0]        state_raw;
  logic              accept, done, expire;
  logic [CMD_W-1:0]  cmd_d, cmd_q;
  logic [RSP_W-1:0]  rsp_d, rsp_q;

  dffr #(.W(2)) u_state_reg (
    .clk(pclk), .rst_n(presetn), .en(1'b1), .d(state_d), .q(state_raw)
  );
  assign state_q = state_t'(state_raw);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i)      state_d = SETUP;
      SETUP:                         state_d = ACCESS;
      ACCESS:  if (pready || expire) state_d = RESP;
      RESP:    if (rsp_ready_i)      state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    psel        = (state_q == SETUP) || (state_q == ACCESS);
    penable     = (state_q == ACCESS);
    rsp_valid_o = (state_q == RESP);
  end

  assign accept = req_valid_i && (state_q == IDLE);
  assign done   = (state_q == ACCESS) && (pready || expire);

  // Reads drive zero data and strobes onto the bus, so mask them at capture time.
  assign cmd_d = {req_addr_i, req_write_i,
                  req_write_i ? req_wdata_i : '0,
                  req_write_i ? req_strb_i  : '0};

  dffr #(.W(CMD_W)) u_cmd_reg (
    .clk(pclk), .rst_n(presetn), .en(accept), .d(cmd_d), .q(cmd_q)
  );
  assign {paddr, pwrite, pwdata, pstrb} = cmd_q;

  dffr #(.W(3), .RST_VAL(APB_PROT_DEFAULT)) u_prot_reg (
    .clk(pclk), .rst_n(presetn), .en(accept), .d(req_prot_i), .q(pprot)
  );

  apb4_mst_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk   (pclk),
    .rst_n (presetn),
    .clr   (state_q == SETUP),
    .en    ((state_q == ACCESS) && !pready),
    .expire(expire)
  );

  // A real completion beats a timeout that lands in the same cycle.
  always_comb begin
    rsp_d = '0;
    if (pready) begin
      rsp_d[RSP_W-1:2] = (!pwrite && !pslverr) ? prdata : '0;
      rsp_d[1]         = pslverr;
    end else begin
      rsp_d[1:0] = 2'b11;
    end
  end

  dffr #(.W(RSP_W)) u_rsp_reg (
    .clk(pclk), .rst_n(presetn), .en(done), .d(rsp_d), .q(rsp_q)
  );
  assign {rsp_rdata_o, rsp_err_o, rsp_timeout_o} = rsp_q;

endmodule
